// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory address, and registers each
// fetched word into the IF/ID pipeline register. Supports stall, redirect and halting.
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSN  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instruction,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CW   = 32;
  localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_BYTES);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);
  localparam logic [CW-1:0]   COUNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_ifid_pc, w_ifid_pc_nxt;
  logic [ILEN-1:0] r_ifid_instruction, w_ifid_instruction_nxt;
  logic            r_ifid_valid, w_ifid_valid_nxt;
  logic            r_halted, w_halted_nxt;
  logic [CW-1:0]   r_fetch_count, w_fetch_count_nxt;
  logic [XLEN-1:0] w_target;
  logic            w_fetch_stop;

  // Range check first so memory data is never consulted past the end of memory.
  always_comb begin
    w_target     = redirect_target & ALIGN_MSK;
    w_fetch_stop = (r_pc >= MEM_LIMIT) || (Instruction == '0);
  end

  always_comb begin
    w_state_nxt            = r_state;
    w_pc_nxt               = r_pc;
    w_ifid_pc_nxt          = r_ifid_pc;
    w_ifid_instruction_nxt = r_ifid_instruction;
    w_ifid_valid_nxt       = r_ifid_valid;
    w_fetch_count_nxt      = r_fetch_count;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt      = ST_RUN;
        w_ifid_valid_nxt = 1'b0;
        if (redirect_valid) w_pc_nxt = w_target;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          w_pc_nxt               = w_target;
          w_ifid_instruction_nxt = NOP_INSN;
          w_ifid_valid_nxt       = 1'b0;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (w_fetch_stop) begin
          w_state_nxt            = ST_HALT;
          w_ifid_instruction_nxt = NOP_INSN;
          w_ifid_valid_nxt       = 1'b0;
        end else begin
          w_ifid_pc_nxt          = r_pc;
          w_ifid_instruction_nxt = Instruction;
          w_ifid_valid_nxt       = 1'b1;
          w_pc_nxt               = r_pc + PC_STEP;
          w_fetch_count_nxt      = (r_fetch_count == COUNT_MAX) ? COUNT_MAX
                                                                : r_fetch_count + CW'(1);
        end
      end
      ST_HALT: begin
        w_ifid_valid_nxt = 1'b0;
        if (redirect_valid) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_halted_nxt = (w_state_nxt == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= ST_IDLE;
      r_pc               <= RESET_PC;
      r_ifid_pc          <= '0;
      r_ifid_instruction <= NOP_INSN;
      r_ifid_valid       <= 1'b0;
      r_halted           <= 1'b0;
      r_fetch_count      <= '0;
    end else begin
      r_state            <= w_state_nxt;
      r_pc               <= w_pc_nxt;
      r_ifid_pc          <= w_ifid_pc_nxt;
      r_ifid_instruction <= w_ifid_instruction_nxt;
      r_ifid_valid       <= w_ifid_valid_nxt;
      r_halted           <= w_halted_nxt;
      r_fetch_count      <= w_fetch_count_nxt;
    end
  end

  assign Inst_Address     = r_pc;
  assign ifid_pc          = r_ifid_pc;
  assign ifid_instruction = r_ifid_instruction;
  assign ifid_valid       = r_ifid_valid;
  assign halted           = r_halted;
  assign fetch_count      = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: directed scenarios plus random stall/redirect/reset
// traffic checked against a behavioural fetch model with its own byte memory.
module tb_instruction_fetch_stage;

  localparam int unsigned MEM_BYTES = 1024;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instruction;
  logic        ifid_valid, halted;
  logic [31:0] fetch_count;

  logic [7:0]  mem [MEM_BYTES];
  logic [9:0]  fidx;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic        m_fresh, m_halt, m_v;
  logic [63:0] m_pc, m_ifid_pc;
  logic [31:0] m_ins, m_cnt;

  instruction_fetch_stage #(.RESET_PC(64'h0), .MEM_BYTES(MEM_BYTES), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .ifid_pc(ifid_pc), .ifid_instruction(ifid_instruction), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Out-of-range addresses return nonzero garbage so only the range check can halt there.
  assign fidx        = Inst_Address[9:0];
  assign Instruction = (Inst_Address < 64'(MEM_BYTES))
                     ? {mem[fidx + 10'd3], mem[fidx + 10'd2], mem[fidx + 10'd1], mem[fidx]}
                     : 32'hDEADBEEF;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic rv,
                            input logic [63:0] tg);
    logic [63:0] t;
    t = {tg[63:2], 2'b00};
    if (rst) begin
      m_pc = 64'h0; m_ifid_pc = 64'h0; m_ins = NOP; m_v = 1'b0; m_cnt = 32'h0;
      m_fresh = 1'b1; m_halt = 1'b0;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      if (rv) m_pc = t;
    end else if (m_halt) begin
      if (rv) begin m_pc = t; m_halt = 1'b0; end
    end else if (rv) begin
      m_pc = t; m_ins = NOP; m_v = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m_pc >= 64'(MEM_BYTES) || word_at(m_pc) == 32'h0) begin
      m_halt = 1'b1; m_v = 1'b0; m_ins = NOP;
    end else begin
      m_ifid_pc = m_pc; m_ins = word_at(m_pc); m_v = 1'b1; m_pc = m_pc + 64'd4;
      if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all();
    check_eq("addr",   Inst_Address,     m_pc);
    check_eq("ifid_pc", ifid_pc,         m_ifid_pc);
    check_eq("ifid_ins", 64'(ifid_instruction), 64'(m_ins));
    check_eq("ifid_v", 64'(ifid_valid),  64'(m_v));
    check_eq("halted", 64'(halted),      64'(m_halt));
    check_eq("count",  64'(fetch_count), 64'(m_cnt));
  endtask

  // Drive at the falling edge, step the model, sample 1 time unit after the rising edge.
  task automatic do_cycle(input logic rst, input logic st, input logic rv, input logic [63:0] tg);
    reset = rst; stall = st; redirect_valid = rv; redirect_target = tg;
    model_step(rst, st, rv, tg);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < int'(MEM_BYTES / 4); i++) begin
      w = $urandom() | 32'h1;
      {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]} = w;
    end
    mem[0] = 8'h13; mem[1] = 8'h06; mem[2] = 8'h10; mem[3] = 8'h00;
    {mem[16'h57], mem[16'h56], mem[16'h55], mem[16'h54]} = 32'h0;
    for (int k = 0; k < 6; k++) begin
      int j;
      j = int'($urandom_range(64, 254));
      {mem[4*j+3], mem[4*j+2], mem[4*j+1], mem[4*j]} = 32'h0;
    end

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 64'h0;
    @(negedge clk);

    // T1: reset, then first fetch on the second edge after reset drops
    do_cycle(1'b1, 1'b0, 1'b0, 64'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 64'h0);
    check_eq("t1_rst_ins", 64'(ifid_instruction), 64'(NOP));
    check_eq("t1_rst_v", 64'(ifid_valid), 64'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t1_idle_v", 64'(ifid_valid), 64'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t1_pc", ifid_pc, 64'h0);
    check_eq("t1_ins", 64'(ifid_instruction), 64'h00100613);
    check_eq("t1_v", 64'(ifid_valid), 64'h1);
    check_eq("t1_addr", Inst_Address, 64'h4);
    check_eq("t1_cnt", 64'(fetch_count), 64'h1);

    // T2: stall three cycles at PC=8
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 64'h0);
      check_eq("t2_addr", Inst_Address, 64'h8);
      check_eq("t2_cnt", 64'(fetch_count), 64'h2);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t2_release", ifid_pc, 64'h8);

    // T3: redirect overrides stall, target low bits cleared
    do_cycle(1'b0, 1'b1, 1'b1, 64'h4E);
    check_eq("t3_addr", Inst_Address, 64'h4C);
    check_eq("t3_v", 64'(ifid_valid), 64'h0);
    check_eq("t3_ins", 64'(ifid_instruction), 64'(NOP));

    // T4: zero word at 0x54 halts; redirect to 0x4 resumes
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t4_halt", 64'(halted), 64'h1);
    check_eq("t4_addr", Inst_Address, 64'h54);
    check_eq("t4_v", 64'(ifid_valid), 64'h0);
    do_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check_eq("t4_stall_ign", 64'(halted), 64'h1);
    do_cycle(1'b0, 1'b0, 1'b1, 64'h4);
    check_eq("t4_resume", 64'(halted), 64'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t4_pc", ifid_pc, 64'h4);

    // T5: last word in memory fetched, then out-of-range halt
    do_cycle(1'b0, 1'b0, 1'b1, 64'h3FC);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t5_pc", ifid_pc, 64'h3FC);
    check_eq("t5_v", 64'(ifid_valid), 64'h1);
    check_eq("t5_addr", Inst_Address, 64'h400);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t5_halt", 64'(halted), 64'h1);
    check_eq("t5_hold", Inst_Address, 64'h400);

    // T6: reset while running at 0x30
    do_cycle(1'b0, 1'b0, 1'b1, 64'h30);
    check_eq("t6_run", Inst_Address, 64'h30);
    do_cycle(1'b1, 1'b0, 1'b0, 64'h0);
    check_eq("t6_addr", Inst_Address, 64'h0);
    check_eq("t6_v", 64'(ifid_valid), 64'h0);
    check_eq("t6_cnt", 64'(fetch_count), 64'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t6_idle", Inst_Address, 64'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic r, s, v;
      logic [63:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 9) == 0);
      t = 64'($urandom_range(0, 1087));
      do_cycle(r, s, v, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
